instr_fetch_ctrl: RTL and testbench

Sequences instruction supply for the 8-bit single-issue CPU. Owns the 32-bit PC and runs a busywait-style read handshake with instruction memory. Holds each fetched word in a buffer until the datapath consumes it, then advances the PC sequentially or to a redirect target. Sits between instruction memory and the cpu datapath/control unit, and replaces the free-running PC+4 update.

---
 rtl/instr_fetch_ctrl.sv | 77 +++++++
 tb/tb_instr_fetch_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, runs a busywait read handshake, and buffers one word until consumed.
// Latency: at least one cycle in FETCH, so peak throughput is one word every two cycles. STALL holds the issued word and the PC.
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    output logic             IMEM_READ,
    output logic [31:0]      IMEM_ADDR,
    input  logic [31:0]      IMEM_RDATA,
    input  logic             IMEM_BUSYWAIT,
    input  logic             STALL,
    input  logic             REDIRECT,
    input  logic [31:0]      REDIRECT_PC,
    input  logic             HALT,
    output logic [31:0]      PC,
    output logic [31:0]      INSTRUCTION,
    output logic             INSTR_VALID,
    output logic             HALTED,
    output logic [CNT_W-1:0] FETCH_COUNT
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_ISSUE  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    localparam logic [31:0]      PC_INC  = 32'(PC_STEP);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t state;

    // Reset clears state immediately, so a pending read is dropped without waiting for an edge.
    assign IMEM_READ = (state == S_FETCH);
    assign HALTED    = (state == S_HALTED);
    assign IMEM_ADDR = PC;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            PC          <= RESET_PC;
            INSTRUCTION <= 32'h0;
            INSTR_VALID <= 1'b0;
            FETCH_COUNT <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (!IMEM_BUSYWAIT) begin
                        INSTRUCTION <= IMEM_RDATA;
                        INSTR_VALID <= 1'b1;
                        FETCH_COUNT <= FETCH_COUNT + CNT_ONE;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // HALT wins over REDIRECT; both are only honoured on the consuming edge.
                    if (!STALL) begin
                        INSTR_VALID <= 1'b0;
                        if (HALT) begin
                            state <= S_HALTED;
                        end else begin
                            PC    <= REDIRECT ? (REDIRECT_PC & 32'hFFFF_FFFC) : (PC + PC_INC);
                            state <= S_FETCH;
                        end
                    end
                end
                default: state <= S_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Scoreboarded bench for instr_fetch_ctrl: expected issues are queued as stimulus is driven and checked when INSTR_VALID rises.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_read;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_busywait = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt = 1'b0;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        halted;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [15:0] cnt;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h0000_0004) return 32'h0002_0103;
        return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
    endfunction

    assign imem_rdata = imem_read ? word_at(imem_addr) : 32'hDEAD_BEEF;

    instr_fetch_ctrl #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4),
        .CNT_W   (16)
    ) dut (
        .CLK          (clk),
        .RESET        (reset),
        .IMEM_READ    (imem_read),
        .IMEM_ADDR    (imem_addr),
        .IMEM_RDATA   (imem_rdata),
        .IMEM_BUSYWAIT(imem_busywait),
        .STALL        (stall),
        .REDIRECT     (redirect),
        .REDIRECT_PC  (redirect_pc),
        .HALT         (halt),
        .PC           (pc),
        .INSTRUCTION  (instruction),
        .INSTR_VALID  (instr_valid),
        .HALTED       (halted),
        .FETCH_COUNT  (fetch_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] p, input logic [15:0] c);
        exp_t e;
        e.pc    = p;
        e.instr = word_at(p);
        e.cnt   = c;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset         = 1'b1;
        imem_busywait = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = 32'h0;
        halt          = 1'b0;
        #1;
        check("rst_read",  imem_read,   0);
        check("rst_pc",    pc,          0);
        check("rst_instr", instruction, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_halted", halted,     0);
        check("rst_count", fetch_count, 0);
        tick(1);
        reset = 1'b0;
    endtask

    // Scoreboard side: each new issue window pops one expected word.
    logic prev_valid = 1'b0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        check("addr_eq_pc", imem_addr, pc);
        if (instr_valid && !prev_valid) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_issue", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc",    pc,          e.pc);
                check("sb_instr", instruction, e.instr);
                check("sb_count", fetch_count, e.cnt);
            end
        end
        prev_valid = instr_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Back-to-back fetches with no wait states.
        reset_dut();
        for (int i = 0; i < 4; i++) push(32'(4 * i), 16'(i + 1));
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            check("a_valid_alt", instr_valid, (i % 2 == 0) ? 1 : 0);
        end
        check("a_count", fetch_count, 4);
        check("a_drained", sb_q.size(), 0);

        // Memory wait states on the fetch at PC=4.
        reset_dut();
        push(32'h0, 16'd1);
        push(32'h4, 16'd2);
        tick(3);
        imem_busywait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("b_read_held", imem_read,   1);
            check("b_addr_held", imem_addr,   32'h4);
            check("b_not_valid", instr_valid, 0);
        end
        imem_busywait = 1'b0;
        tick(1);
        check("b_word",  instruction, 32'h0002_0103);
        check("b_count", fetch_count, 2);
        check("b_drained", sb_q.size(), 0);

        // Stall with an ignored redirect, then redirect, PC wrap and halt.
        reset_dut();
        push(32'h0, 16'd1);
        tick(2);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick(1);
        check("c_stall_pc",    pc,          0);
        check("c_stall_instr", instruction, word_at(32'h0));
        check("c_stall_valid", instr_valid, 1);
        redirect = 1'b0;
        tick(1);
        check("c_stall2_pc",    pc,          0);
        check("c_stall2_valid", instr_valid, 1);
        stall = 1'b0;
        push(32'h4, 16'd2);
        tick(1);
        check("c_release_pc", pc, 32'h4);
        check("c_release_valid", instr_valid, 0);
        tick(1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0043;
        push(32'h40, 16'd3);
        tick(1);
        check("d_redir_addr", imem_addr, 32'h0000_0040);
        check("d_redir_read", imem_read, 1);
        redirect_pc = 32'hFFFF_FFFF;
        push(32'hFFFF_FFFC, 16'd4);
        tick(2);
        check("d_top_pc", pc, 32'hFFFF_FFFC);
        redirect = 1'b0;
        push(32'h0, 16'd5);
        tick(2);
        check("d_wrap_pc", pc, 32'h0);
        tick(1);
        halt        = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0080;
        tick(1);
        check("e_halted", halted,      1);
        check("e_pc",     pc,          0);
        check("e_valid",  instr_valid, 0);
        halt     = 1'b0;
        redirect = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("e_read_low", imem_read, 0);
            check("e_stay_halted", halted, 1);
        end
        check("e_drained", sb_q.size(), 0);

        // Asynchronous reset in the middle of a stalled fetch.
        reset_dut();
        push(32'h0, 16'd1);
        tick(2);
        imem_busywait = 1'b1;
        tick(1);
        check("f_pre_read", imem_read, 1);
        check("f_pre_pc",   pc,        32'h4);
        reset = 1'b1;
        #1;
        check("f_async_read", imem_read, 0);
        check("f_async_pc",   pc,        0);
        #1;
        reset         = 1'b0;
        imem_busywait = 1'b0;
        push(32'h0, 16'd1);
        tick(3);
        check("f_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
